dhnf: RTL and testbench

DHNF -- requirements
Module: dhnf

---
 rtl/dhnf_pkg.sv | 17 +
 rtl/dhnf_match.sv | 60 ++++++
 rtl/dhnf.sv | 111 +++++++++++
 tb/tb_dhnf.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dhnf_pkg.sv
// Shared types and sizes for the DHNF hazard-detection and forwarding unit.
package dhnf_pkg;

  localparam int REG_ADDR_W  = 5;
  localparam int XLEN        = 32;
  localparam int STALL_CNT_W = 16;

  // One in-flight instruction as seen by the hazard unit.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } track_entry_t;

  localparam track_entry_t BUBBLE = '0;

endpackage

// File: rtl/dhnf_match.sv
// Per-read-port operand match and forward selection.
// Optional feature macro: DHNF_WB_BYPASS_EN (WB entry also forwards; otherwise
// the register file's write-first bypass covers the WB stage).
module dhnf_match
  import dhnf_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] raddr,
  input  logic                  re,
  input  track_entry_t          ex_entry,
  input  track_entry_t          mem_entry,
  input  track_entry_t          wb_entry,
  input  logic [XLEN-1:0]       ex_data,
  input  logic [XLEN-1:0]       mem_data,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  sel,
  output logic [XLEN-1:0]       data,
  output logic                  load_hit
);

  logic reading;
  logic hit_ex;
  logic hit_mem;
  logic hit_wb;

  // x0 reads never match anything, so the zero register can't be forwarded.
  assign reading = re && (raddr != '0);
  assign hit_ex  = reading && ex_entry.valid  && (ex_entry.rd  == raddr);
  assign hit_mem = reading && mem_entry.valid && (mem_entry.rd == raddr);

`ifdef DHNF_WB_BYPASS_EN
  assign hit_wb  = reading && wb_entry.valid  && (wb_entry.rd  == raddr);
`else
  logic unused_wb;
  assign hit_wb    = 1'b0;
  assign unused_wb = ^{wb_entry, wb_data};
`endif

  // Youngest producer wins; a load still in EX has no data yet, so it
  // blocks older entries and requests a stall instead of forwarding.
  always_comb begin
    sel      = 1'b0;
    data     = '0;
    load_hit = 1'b0;
    if (hit_ex) begin
      if (ex_entry.is_load) begin
        load_hit = 1'b1;
      end else begin
        sel  = 1'b1;
        data = ex_data;
      end
    end else if (hit_mem) begin
      sel  = 1'b1;
      data = mem_data;
    end else if (hit_wb) begin
      sel  = 1'b1;
      data = wb_data;
    end
  end

endmodule

// File: rtl/dhnf.sv
// DHNF: data-hazard detection and forwarding for a 5-stage pipeline.
// Tracks rd of the instructions in EX/MEM/WB, forwards results to the two ID
// read ports and raises a one-cycle load-use stall.
// Optional feature macro: DHNF_WB_BYPASS_EN (see dhnf_match).
module dhnf
  import dhnf_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  id_reg1_raddr_i,
  input  logic [REG_ADDR_W-1:0]  id_reg2_raddr_i,
  input  logic                   id_reg1_RE_i,
  input  logic                   id_reg2_RE_i,
  input  logic [REG_ADDR_W-1:0]  id_reg_waddr_i,
  input  logic                   id_reg_we_i,
  input  logic                   id_mem_re_i,
  input  logic [XLEN-1:0]        ex_result_i,
  input  logic [XLEN-1:0]        mem_result_i,
  input  logic [XLEN-1:0]        wb_wdata_i,
  input  logic                   hold_i,
  input  logic                   flush_i,
  output logic                   dhnf_harzard_sel1_o,
  output logic                   dhnf_harzard_sel2_o,
  output logic [XLEN-1:0]        dhnf_forward_data1_o,
  output logic [XLEN-1:0]        dhnf_forward_data2_o,
  output logic                   dhnf_stall_o,
  output logic [STALL_CNT_W-1:0] dhnf_stall_cnt_o
);

  track_entry_t ex_reg;
  track_entry_t mem_reg;
  track_entry_t wb_reg;
  track_entry_t ex_next;

  logic [STALL_CNT_W-1:0] stall_cnt_reg;
  logic [STALL_CNT_W-1:0] stall_cnt_next;

  logic [REG_ADDR_W-1:0] port_raddr [2];
  logic [1:0]            port_re;
  logic [1:0]            port_sel;
  logic [XLEN-1:0]       port_data [2];
  logic [1:0]            port_load_hit;
  logic                  stall;

  assign port_raddr[0] = id_reg1_raddr_i;
  assign port_raddr[1] = id_reg2_raddr_i;
  assign port_re       = {id_reg2_RE_i, id_reg1_RE_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      dhnf_match u_match (
        .raddr     (port_raddr[gi]),
        .re        (port_re[gi]),
        .ex_entry  (ex_reg),
        .mem_entry (mem_reg),
        .wb_entry  (wb_reg),
        .ex_data   (ex_result_i),
        .mem_data  (mem_result_i),
        .wb_data   (wb_wdata_i),
        .sel       (port_sel[gi]),
        .data      (port_data[gi]),
        .load_hit  (port_load_hit[gi])
      );
    end
  endgenerate

  // A killed ID instruction never consumes its operands, so flush masks the stall.
  assign stall = (|port_load_hit) && !flush_i;

  assign dhnf_harzard_sel1_o  = port_sel[0];
  assign dhnf_harzard_sel2_o  = port_sel[1];
  assign dhnf_forward_data1_o = port_data[0];
  assign dhnf_forward_data2_o = port_data[1];
  assign dhnf_stall_o         = stall;
  assign dhnf_stall_cnt_o     = stall_cnt_reg;

  // Entry entering EX: a bubble when ID is killed or stalled, x0 never tracked.
  always_comb begin
    ex_next = BUBBLE;
    if (!(flush_i || stall)) begin
      ex_next.valid   = id_reg_we_i && (id_reg_waddr_i != '0);
      ex_next.rd      = id_reg_waddr_i;
      ex_next.is_load = id_mem_re_i;
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (stall && (stall_cnt_reg != '1)) begin
      stall_cnt_next = stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  // Tracking pipeline and counter; reset beats hold, hold freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_reg        <= BUBBLE;
      mem_reg       <= BUBBLE;
      wb_reg        <= BUBBLE;
      stall_cnt_reg <= '0;
    end else if (!hold_i) begin
      ex_reg        <= ex_next;
      mem_reg       <= ex_reg;
      wb_reg        <= mem_reg;
      stall_cnt_reg <= stall_cnt_next;
    end
  end

endmodule

// File: tb/tb_dhnf.sv
// Self-checking bench for dhnf: directed scenarios plus a randomized run
// against an in-flight-instruction reference model.
module tb_dhnf;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_reg1_raddr_i, id_reg2_raddr_i, id_reg_waddr_i;
  logic        id_reg1_RE_i, id_reg2_RE_i, id_reg_we_i, id_mem_re_i;
  logic [31:0] ex_result_i, mem_result_i, wb_wdata_i;
  logic        hold_i, flush_i;
  logic        sel1, sel2, stall;
  logic [31:0] data1, data2;
  logic [15:0] cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dhnf dut (
    .clk                  (clk),
    .rst                  (rst),
    .id_reg1_raddr_i      (id_reg1_raddr_i),
    .id_reg2_raddr_i      (id_reg2_raddr_i),
    .id_reg1_RE_i         (id_reg1_RE_i),
    .id_reg2_RE_i         (id_reg2_RE_i),
    .id_reg_waddr_i       (id_reg_waddr_i),
    .id_reg_we_i          (id_reg_we_i),
    .id_mem_re_i          (id_mem_re_i),
    .ex_result_i          (ex_result_i),
    .mem_result_i         (mem_result_i),
    .wb_wdata_i           (wb_wdata_i),
    .hold_i               (hold_i),
    .flush_i              (flush_i),
    .dhnf_harzard_sel1_o  (sel1),
    .dhnf_harzard_sel2_o  (sel2),
    .dhnf_forward_data1_o (data1),
    .dhnf_forward_data2_o (data2),
    .dhnf_stall_o         (stall),
    .dhnf_stall_cnt_o     (cnt)
  );

  // ---------------- reference model ----------------
  // Instructions in flight, youngest first: age 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit writes;
    int rd;
    bit load;
  } instr_t;

`ifdef DHNF_WB_BYPASS_EN
  localparam int NSRC = 3;
`else
  localparam int NSRC = 2;
`endif

  typedef struct packed {
    logic        sel;
    logic [31:0] d;
    logic        lh;
  } fwd_t;

  instr_t flight [3];
  int     m_cnt;

  function automatic fwd_t model_port(input logic re, input logic [4:0] ra);
    fwd_t r;
    logic [31:0] src [3];
    src[0] = ex_result_i;
    src[1] = mem_result_i;
    src[2] = wb_wdata_i;
    r = '0;
    if (re && ra != 0) begin
      for (int a = 0; a < NSRC; a++) begin
        if (flight[a].writes && flight[a].rd == int'(ra)) begin
          if (a == 0 && flight[a].load) r.lh = 1'b1;
          else begin
            r.sel = 1'b1;
            r.d   = src[a];
          end
          break;
        end
      end
    end
    return r;
  endfunction

  function automatic bit model_stall();
    fwd_t p1, p2;
    p1 = model_port(id_reg1_RE_i, id_reg1_raddr_i);
    p2 = model_port(id_reg2_RE_i, id_reg2_raddr_i);
    return (p1.lh || p2.lh) && !flush_i;
  endfunction

  // One clock edge; the model advances with the inputs present at the edge.
  task automatic tick();
    bit st;
    instr_t nw;
    st = model_stall();
    nw.writes = id_reg_we_i && (id_reg_waddr_i != 0) && !flush_i && !st;
    nw.rd     = int'(id_reg_waddr_i);
    nw.load   = id_mem_re_i;
    @(posedge clk);
    if (rst) begin
      for (int a = 0; a < 3; a++) flight[a] = '{0, 0, 0};
      m_cnt = 0;
    end else if (!hold_i) begin
      flight[2] = flight[1];
      flight[1] = flight[0];
      flight[0] = nw;
      if (st && m_cnt < 65535) m_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    id_reg1_raddr_i = 0; id_reg2_raddr_i = 0; id_reg_waddr_i = 0;
    id_reg1_RE_i = 0; id_reg2_RE_i = 0; id_reg_we_i = 0; id_mem_re_i = 0;
    ex_result_i = 0; mem_result_i = 0; wb_wdata_i = 0;
    hold_i = 0; flush_i = 0; rst = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    id_reg1_raddr_i = 5'd3; id_reg1_RE_i = 1;
    id_reg2_raddr_i = 5'd7; id_reg2_RE_i = 1;
    ex_result_i = 32'h1111; mem_result_i = 32'h2222; wb_wdata_i = 32'h3333;
    @(negedge clk);
    total++; if ({sel1, sel2, stall} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {sel1, sel2, stall}); end
    total++; if (data1 !== 32'h0) begin bad++; $display("FAIL reset_data1 got=%h exp=0", data1); end
    total++; if (data2 !== 32'h0) begin bad++; $display("FAIL reset_data2 got=%h exp=0", data2); end
    total++; if (cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    $display("test_reset done");
  endtask

  task automatic test_forward_ex();
    do_reset();
    id_reg_we_i = 1; id_reg_waddr_i = 5'd3;
    tick();
    idle();
    ex_result_i = 32'h10; id_reg1_raddr_i = 5'd3; id_reg1_RE_i = 1;
    @(negedge clk);
    total++; if (sel1 !== 1'b1) begin bad++; $display("FAIL ex_fwd_sel1 got=%b exp=1", sel1); end
    total++; if (data1 !== 32'h10) begin bad++; $display("FAIL ex_fwd_data1 got=%h exp=10", data1); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ex_fwd_stall got=%b exp=0", stall); end
    $display("test_forward_ex done");
  endtask

  task automatic test_load_use();
    do_reset();
    id_reg_we_i = 1; id_reg_waddr_i = 5'd5; id_mem_re_i = 1;
    tick();
    idle();
    id_reg2_raddr_i = 5'd5; id_reg2_RE_i = 1; mem_result_i = 32'hDEAD_BEEF;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall); end
    total++; if (sel2 !== 1'b0) begin bad++; $display("FAIL lu_sel2_during got=%b exp=0", sel2); end
    tick();
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_stall_after got=%b exp=0", stall); end
    total++; if (sel2 !== 1'b1) begin bad++; $display("FAIL lu_sel2 got=%b exp=1", sel2); end
    total++; if (data2 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lu_data2 got=%h exp=deadbeef", data2); end
    total++; if (cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
    $display("test_load_use done");
  endtask

  task automatic test_priority();
    do_reset();
    id_reg_we_i = 1; id_reg_waddr_i = 5'd4;
    tick();
    tick();
    idle();
    ex_result_i = 32'h1; mem_result_i = 32'h2;
    id_reg1_raddr_i = 5'd4; id_reg1_RE_i = 1;
    id_reg2_raddr_i = 5'd4; id_reg2_RE_i = 1;
    @(negedge clk);
    total++; if ({sel1, sel2} !== 2'b11) begin bad++; $display("FAIL prio_sel got=%b exp=11", {sel1, sel2}); end
    total++; if (data1 !== 32'h1) begin bad++; $display("FAIL prio_data1 got=%h exp=1", data1); end
    total++; if (data2 !== 32'h1) begin bad++; $display("FAIL prio_data2 got=%h exp=1", data2); end
    $display("test_priority done");
  endtask

  task automatic test_x0();
    do_reset();
    id_reg_we_i = 1; id_reg_waddr_i = 5'd0;
    tick();
    idle();
    ex_result_i = 32'hCAFE_0001; mem_result_i = 32'hCAFE_0002;
    id_reg1_raddr_i = 5'd0; id_reg1_RE_i = 1;
    @(negedge clk);
    total++; if (sel1 !== 1'b0) begin bad++; $display("FAIL x0_sel1 got=%b exp=0", sel1); end
    total++; if (data1 !== 32'h0) begin bad++; $display("FAIL x0_data1 got=%h exp=0", data1); end
    $display("test_x0 done");
  endtask

  task automatic test_flush();
    do_reset();
    id_reg_we_i = 1; id_reg_waddr_i = 5'd7; id_mem_re_i = 1;
    tick();
    idle();
    // killed instruction reads the load result and would write x9
    id_reg1_raddr_i = 5'd7; id_reg1_RE_i = 1; flush_i = 1;
    id_reg_we_i = 1; id_reg_waddr_i = 5'd9;
    @(negedge clk);
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall); end
    total++; if (sel1 !== 1'b0) begin bad++; $display("FAIL flush_sel1 got=%b exp=0", sel1); end
    tick();
    idle();
    ex_result_i = 32'h9999; mem_result_i = 32'h7777;
    id_reg2_raddr_i = 5'd9; id_reg2_RE_i = 1;
    @(negedge clk);
    total++; if (sel2 !== 1'b0) begin bad++; $display("FAIL flush_bubble_sel2 got=%b exp=0", sel2); end
    total++; if (data2 !== 32'h0) begin bad++; $display("FAIL flush_bubble_data2 got=%h exp=0", data2); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", cnt); end
    $display("test_flush done");
  endtask

  task automatic test_hold_reset();
    do_reset();
    id_reg_we_i = 1; id_reg_waddr_i = 5'd8;
    tick();
    id_reg_waddr_i = 5'd9;
    tick();
    // EX holds x9, MEM holds x8; new ID writer of x10 must not enter
    hold_i = 1; id_reg_waddr_i = 5'd10;
    ex_result_i = 32'hAAAA_0009; mem_result_i = 32'hBBBB_0008;
    for (int h = 0; h < 3; h++) begin
      tick();
      id_reg1_raddr_i = 5'd9; id_reg1_RE_i = 1;
      id_reg2_raddr_i = 5'd8; id_reg2_RE_i = 1;
      @(negedge clk);
      total++; if ({sel1, sel2} !== 2'b11) begin bad++; $display("FAIL hold_sel cyc=%0d got=%b exp=11", h, {sel1, sel2}); end
      total++; if (data1 !== 32'hAAAA_0009) begin bad++; $display("FAIL hold_data1 cyc=%0d got=%h exp=aaaa0009", h, data1); end
      total++; if (data2 !== 32'hBBBB_0008) begin bad++; $display("FAIL hold_data2 cyc=%0d got=%h exp=bbbb0008", h, data2); end
    end
    rst = 1; flush_i = 1;
    tick();
    rst = 0; hold_i = 0; flush_i = 0; id_reg_we_i = 0;
    @(negedge clk);
    total++; if ({sel1, sel2, stall} !== 3'b000) begin bad++; $display("FAIL hrst_flags got=%b exp=000", {sel1, sel2, stall}); end
    total++; if ({data1, data2} !== 64'h0) begin bad++; $display("FAIL hrst_data got=%h_%h exp=0_0", data1, data2); end
    total++; if (cnt !== 16'd0) begin bad++; $display("FAIL hrst_cnt got=%0d exp=0", cnt); end
    $display("test_hold_reset done");
  endtask

  task automatic test_random();
    fwd_t p1, p2;
    bit   st;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      id_reg1_raddr_i = 5'($urandom_range(0, 6));
      id_reg2_raddr_i = 5'($urandom_range(0, 6));
      id_reg1_RE_i    = 1'($urandom_range(0, 3) != 0);
      id_reg2_RE_i    = 1'($urandom_range(0, 3) != 0);
      id_reg_waddr_i  = 5'($urandom_range(0, 6));
      id_reg_we_i     = 1'($urandom_range(0, 3) != 0);
      id_mem_re_i     = 1'($urandom_range(0, 2) == 0);
      hold_i          = 1'($urandom_range(0, 4) == 0);
      flush_i         = 1'($urandom_range(0, 5) == 0);
      ex_result_i     = $urandom;
      mem_result_i    = $urandom;
      wb_wdata_i      = $urandom;
      @(negedge clk);
      p1 = model_port(id_reg1_RE_i, id_reg1_raddr_i);
      p2 = model_port(id_reg2_RE_i, id_reg2_raddr_i);
      st = model_stall();
      total++; if (sel1 !== p1.sel) begin bad++; $display("FAIL rnd_sel1 cyc=%0d got=%b exp=%b", c, sel1, p1.sel); end
      total++; if (data1 !== p1.d) begin bad++; $display("FAIL rnd_data1 cyc=%0d got=%h exp=%h", c, data1, p1.d); end
      total++; if (sel2 !== p2.sel) begin bad++; $display("FAIL rnd_sel2 cyc=%0d got=%b exp=%b", c, sel2, p2.sel); end
      total++; if (data2 !== p2.d) begin bad++; $display("FAIL rnd_data2 cyc=%0d got=%h exp=%h", c, data2, p2.d); end
      total++; if (stall !== st) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, st); end
      total++; if (cnt !== 16'(m_cnt)) begin bad++; $display("FAIL rnd_cnt cyc=%0d got=%0d exp=%0d", c, cnt, m_cnt); end
      tick();
    end
    $display("test_random done stalls=%0d", m_cnt);
  endtask

  initial begin
    for (int a = 0; a < 3; a++) flight[a] = '{0, 0, 0};
    m_cnt = 0;
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_forward_ex();
    test_load_use();
    test_priority();
    test_x0();
    test_flush();
    test_hold_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
